// File: rtl/volume_title_square_pkg.sv
// Shared types and VGA coordinate widths for the sliding title rectangle.
package volume_title_square_pkg;

  localparam int PIX_W = 11;  // VGA pixel coordinate width
  localparam int POS_W = 12;  // signed on-screen position width

  typedef enum logic [1:0] {
    HIDDEN    = 2'd0,
    SLIDE_IN  = 2'd1,
    HOLD      = 2'd2,
    SLIDE_OUT = 2'd3
  } state_e;

endpackage

// File: rtl/volume_title_square.sv
// Title rectangle that slides down into view, holds for a number of frames,
// then slides back up off-screen; produces a registered per-pixel hit test.
module volume_title_square
  import volume_title_square_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 128,
  parameter int OBJECT_HEIGHT = 16,
  parameter int TOP_X         = 256,
  parameter int TARGET_Y      = 40,
  parameter int START_Y       = -16,
  parameter int SLIDE_STEP    = 2,
  parameter int HOLD_FRAMES   = 120
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PIX_W-1:0]                     pixelX,
  input  logic [PIX_W-1:0]                     pixelY,
  input  logic                                 startOfFrame,
  input  logic                                 showTitle,
  output logic [PIX_W-1:0]                     offsetX,
  output logic [PIX_W-1:0]                     offsetY,
  output logic                                 InsideRectangle,
  output logic                                 busy,
  output state_e                               dbg_state,
  output logic signed [POS_W-1:0]              dbg_top_y,
  output logic [$clog2(HOLD_FRAMES+1)-1:0]     dbg_hold_cnt
);

  localparam int HC_W = $clog2(HOLD_FRAMES + 1);

  localparam logic signed [POS_W-1:0] START_Y_S  = POS_W'(START_Y);
  localparam logic signed [POS_W-1:0] TARGET_Y_S = POS_W'(TARGET_Y);
  localparam logic signed [POS_W-1:0] STEP_S     = POS_W'(SLIDE_STEP);
  localparam logic [HC_W-1:0]         HOLD_LAST  = HC_W'(HOLD_FRAMES - 1);

  // One extra bit so that bounds like TOP_X+OBJECT_WIDTH never wrap.
  localparam logic signed [POS_W:0] X_LO  = (POS_W+1)'(TOP_X);
  localparam logic signed [POS_W:0] X_HI  = (POS_W+1)'(TOP_X + OBJECT_WIDTH);
  localparam logic signed [POS_W:0] OBJ_H = (POS_W+1)'(OBJECT_HEIGHT);
  localparam logic [PIX_W-1:0]      X_LO_PIX = PIX_W'(TOP_X);

  state_e                  state, state_nx;
  logic signed [POS_W-1:0] top_y, top_y_nx;
  logic [HC_W-1:0]         hold_cnt, hold_cnt_nx;
  logic signed [POS_W-1:0] y_up, y_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HIDDEN;
      top_y    <= START_Y_S;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      top_y    <= top_y_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // showTitle is a single-cycle request; nothing is latched if the current
  // state ignores it.
  always_comb begin
    state_nx    = state;
    top_y_nx    = top_y;
    hold_cnt_nx = hold_cnt;
    y_up        = top_y + STEP_S;
    y_dn        = top_y - STEP_S;
    case (state)
      HIDDEN: begin
        if (showTitle) begin
          state_nx = SLIDE_IN;
          top_y_nx = START_Y_S;
        end
      end
      SLIDE_IN: begin
        if (startOfFrame) begin
          if (y_up >= TARGET_Y_S) begin
            state_nx    = HOLD;
            top_y_nx    = TARGET_Y_S;
            hold_cnt_nx = '0;
          end else begin
            top_y_nx = y_up;
          end
        end
      end
      HOLD: begin
        if (showTitle) begin
          hold_cnt_nx = '0;
        end else if (startOfFrame) begin
          if (hold_cnt >= HOLD_LAST) begin
            state_nx = SLIDE_OUT;
          end else begin
            hold_cnt_nx = hold_cnt + HC_W'(1);
          end
        end
      end
      SLIDE_OUT: begin
        if (showTitle) begin
          // Reverse direction; a coincident frame pulse also moves it down.
          state_nx = SLIDE_IN;
          if (startOfFrame) begin
            top_y_nx = (y_up >= TARGET_Y_S) ? TARGET_Y_S : y_up;
          end
        end else if (startOfFrame) begin
          if (y_dn <= START_Y_S) begin
            state_nx = HIDDEN;
            top_y_nx = START_Y_S;
          end else begin
            top_y_nx = y_dn;
          end
        end
      end
      default: begin
        state_nx = HIDDEN;
      end
    endcase
  end

  logic signed [POS_W:0] px_s, py_s, ty_s;
  logic                  hit;
  logic [PIX_W-1:0]      off_x, off_y;

  always_comb begin
    px_s  = {2'b00, pixelX};
    py_s  = {2'b00, pixelY};
    ty_s  = {top_y[POS_W-1], top_y};
    hit   = (state != HIDDEN) &&
            (px_s >= X_LO) && (px_s < X_HI) &&
            (py_s >= ty_s) && (py_s < ty_s + OBJ_H);
    off_x = pixelX - X_LO_PIX;
    off_y = pixelY - top_y[PIX_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= hit;
      offsetX         <= hit ? off_x : '0;
      offsetY         <= hit ? off_y : '0;
    end
  end

  assign busy         = (state != HIDDEN);
  assign dbg_state    = state;
  assign dbg_top_y    = top_y;
  assign dbg_hold_cnt = hold_cnt;

endmodule

// File: tb/tb_volume_title_square.sv
// Directed bench for volume_title_square: slide-in, hold, slide-out, pixel
// hit/offset checks, mid-animation reset.
module tb_volume_title_square;
  import volume_title_square_pkg::*;

  localparam int HC_W = $clog2(120 + 1);

  logic               clk;
  logic               reset;
  logic [PIX_W-1:0]   pixelX, pixelY;
  logic               startOfFrame, showTitle;
  logic [PIX_W-1:0]   offsetX, offsetY;
  logic               InsideRectangle, busy;
  state_e             dbg_state;
  logic signed [POS_W-1:0] dbg_top_y;
  logic [HC_W-1:0]    dbg_hold_cnt;

  int errors = 0;
  int checks = 0;
  logic [2*PIX_W:0] exp_q[$];

  volume_title_square dut (
    .clk             (clk),
    .reset           (reset),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .startOfFrame    (startOfFrame),
    .showTitle       (showTitle),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .busy            (busy),
    .dbg_state       (dbg_state),
    .dbg_top_y       (dbg_top_y),
    .dbg_hold_cnt    (dbg_hold_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      @(negedge clk);
    end
    startOfFrame = 1'b0;
  endtask

  task automatic show();
    showTitle = 1'b1;
    @(negedge clk);
    showTitle = 1'b0;
  endtask

  task automatic show_and_frame();
    showTitle    = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    showTitle    = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_state(input string tag, input state_e st, input int ty);
    check({tag, "_state"}, 32'(dbg_state), 32'(st));
    check({tag, "_topy"}, dbg_top_y, ty);
  endtask

  // Scoreboard: expected {InsideRectangle, offsetX, offsetY} one clock later
  task automatic pix(input string tag, input int x, input int y,
                     input logic ei, input int ox, input int oy);
    logic [2*PIX_W:0] e;
    pixelX = PIX_W'(x);
    pixelY = PIX_W'(y);
    exp_q.push_back({ei, PIX_W'(ox), PIX_W'(oy)});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    assert ({InsideRectangle, offsetX, offsetY} === e) else begin
      errors++;
      $error("FAIL %s observed in=%0b ox=%0d oy=%0d expected in=%0b ox=%0d oy=%0d",
             tag, InsideRectangle, offsetX, offsetY, e[2*PIX_W], e[2*PIX_W-1:PIX_W], e[PIX_W-1:0]);
    end
  endtask

  initial begin
    int hits;
    reset        = 1'b1;
    pixelX       = '0;
    pixelY       = '0;
    startOfFrame = 1'b0;
    showTitle    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_inside", InsideRectangle, 0);
    check("rst_offx", offsetX, 0);
    check_state("rst", HIDDEN, -16);
    check("rst_hold", dbg_hold_cnt, 0);
    reset = 1'b0;
    tick();

    // Frames while hidden change nothing
    frames(3);
    check_state("hidden_frames", HIDDEN, -16);

    // Scenario 1: request -> busy next cycle, 28 frames to reach 40
    show();
    check("s1_busy", busy, 1);
    check_state("s1_start", SLIDE_IN, -16);
    frames(5);
    check_state("s1_f5", SLIDE_IN, -6);

    // Scenario 3: negative topY clipping
    pix("s3_top_row", 256, 0, 1'b1, 0, 6);
    pix("s3_below", 256, 10, 1'b0, 0, 0);
    pix("s3_last_row", 383, 9, 1'b1, 127, 15);
    pix("s3_left_miss", 255, 0, 1'b0, 0, 0);

    // Request during slide-in is ignored
    show();
    check_state("s1_ignore", SLIDE_IN, -6);

    frames(22);
    check_state("s1_f27", SLIDE_IN, 38);
    frames(1);
    check_state("s1_f28", HOLD, 40);
    check("s1_hold0", dbg_hold_cnt, 0);

    // Scenario 2: resting position hit test
    pix("s2_hit", 300, 45, 1'b1, 44, 5);
    pix("s2_right_miss", 384, 45, 1'b0, 0, 0);
    pix("s2_corner", 383, 55, 1'b1, 127, 15);
    pix("s2_below_miss", 300, 56, 1'b0, 0, 0);
    pix("s2_top_left", 256, 40, 1'b1, 0, 0);
    pix("s2_above_miss", 300, 39, 1'b0, 0, 0);

    // Scenario 4: hold restart and reversal
    frames(100);
    check("s4_hold100", dbg_hold_cnt, 100);
    show();
    check("s4_cleared", dbg_hold_cnt, 0);
    check_state("s4_still_hold", HOLD, 40);
    frames(3);
    show_and_frame();
    check("s4_both_hold", dbg_hold_cnt, 0);
    frames(119);
    check_state("s4_f119", HOLD, 40);
    check("s4_hold119", dbg_hold_cnt, 119);
    frames(1);
    check_state("s4_out", SLIDE_OUT, 40);
    frames(1);
    check_state("s4_out1", SLIDE_OUT, 38);
    show_and_frame();
    check_state("s4_reverse", SLIDE_IN, 40);
    frames(1);
    check_state("s4_rehold", HOLD, 40);
    check("s4_rehold_cnt", dbg_hold_cnt, 0);

    // Scenario 5: full slide-out back to hidden
    frames(120);
    check_state("s5_out", SLIDE_OUT, 40);
    frames(27);
    check_state("s5_f27", SLIDE_OUT, -14);
    pix("s5_edge_hit", 256, 1, 1'b1, 0, 15);
    pix("s5_edge_miss", 256, 2, 1'b0, 0, 0);
    frames(1);
    check_state("s5_hidden", HIDDEN, -16);
    check("s5_busy", busy, 0);
    frames(1);
    hits = 0;
    for (int y = 0; y < 525; y += 8) begin
      for (int x = 0; x < 800; x += 16) begin
        pixelX = PIX_W'(x);
        pixelY = PIX_W'(y);
        tick();
        hits += int'(InsideRectangle);
      end
    end
    check("s5_no_hits", hits, 0);

    // Scenario 6: asynchronous reset in the middle of HOLD
    show();
    frames(28);
    frames(5);
    check_state("s6_hold", HOLD, 40);
    check("s6_hold5", dbg_hold_cnt, 5);
    pix("s6_hit", 300, 45, 1'b1, 44, 5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("s6_rst_inside", InsideRectangle, 0);
    check("s6_rst_offx", offsetX, 0);
    check("s6_rst_offy", offsetY, 0);
    check("s6_rst_busy", busy, 0);
    check_state("s6_rst", HIDDEN, -16);
    check("s6_rst_hold", dbg_hold_cnt, 0);
    tick();
    reset = 1'b0;
    frames(3);
    check("s6_no_residual", busy, 0);
    show();
    check_state("s6_restart", SLIDE_IN, -16);
    frames(1);
    check_state("s6_restart_f1", SLIDE_IN, -14);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
